// File: rtl/fp32_result_pkg.sv
// rtl/fp32_result_pkg.sv - shared types and constants for the fp32 result FIFO.
package fp32_result_pkg;

   typedef struct packed {
      logic invalid;
      logic overflow;
      logic underflow;
   } fp32_flags_t;

   typedef struct packed {
      logic [31:0] result;
      fp32_flags_t flags;
   } fp32_entry_t;

   localparam logic [31:0] CANON_QNAN   = 32'h7FC00000;
   localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;

   function automatic logic is_nan(input logic [31:0] v);
      return (v[30:23] == FP32_EXP_MAX) && (v[22:0] != 23'd0);
   endfunction

endpackage

// File: rtl/fp32_result_fifo_mem.sv
// rtl/fp32_result_fifo_mem.sv - DEPTH-entry register array, one write port, combinational read.
module fp32_result_fifo_mem
   import fp32_result_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  fp32_entry_t              wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output fp32_entry_t              rdata
);

   fp32_entry_t mem [DEPTH];

   // Cleared on reset so the idle head reads as zero.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fp32_result_fifo.sv
// rtl/fp32_result_fifo.sv - show-ahead result FIFO with in-flight tracking for the fp32 adder.
// Optional: FP32_RESULT_FIFO_NAN_CANON_EN canonicalises pushed NaNs to CANON_QNAN.
module fp32_result_fifo
   import fp32_result_pkg::*;
#(
   parameter int DEPTH        = 8,
   parameter int MAX_INFLIGHT = 8
) (
   input  logic                   clk_i,
   input  logic                   rstn_i,
   input  logic                   issue_i,
   input  logic                   done_i,
   input  logic [31:0]            result_i,
   input  logic                   overflow_i,
   input  logic                   underflow_i,
   input  logic                   invalid_i,
   output logic                   m_valid_o,
   output logic [31:0]            m_result_o,
   output logic [2:0]             m_flags_o,
   input  logic                   m_ready_i,
   output logic                   issue_ok_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic [2:0]             sticky_flags_o,
   input  logic                   clr_sticky_i,
   output logic                   err_overrun_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int IW = $clog2(MAX_INFLIGHT) + 1;
   localparam int SW = ((CW > IW) ? CW : IW) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [IW-1:0] MAX_C   = IW'(MAX_INFLIGHT);

   logic [AW-1:0] wptr, rptr;
   logic [CW-1:0] count;
   logic [IW-1:0] inflight, inflight_next;
   logic          infl_err;
   logic          push, pop, drop;
   fp32_flags_t   sticky;
   fp32_entry_t   wdata, rdata;

   always_comb begin
      wdata.flags = fp32_flags_t'{invalid: invalid_i, overflow: overflow_i, underflow: underflow_i};
`ifdef FP32_RESULT_FIFO_NAN_CANON_EN
      wdata.result = is_nan(result_i) ? CANON_QNAN : result_i;
`else
      wdata.result = result_i;
`endif
   end

   assign pop  = (count != '0) && m_ready_i;
   assign push = done_i && ((count != DEPTH_C) || pop);
   assign drop = done_i && !push;

   // Saturate at both ends; either saturation is a protocol error.
   always_comb begin
      inflight_next = inflight;
      infl_err      = 1'b0;
      if (issue_i && !done_i) begin
         if (inflight == MAX_C) infl_err = 1'b1;
         else                   inflight_next = inflight + 1'b1;
      end else if (done_i && !issue_i) begin
         if (inflight == '0) infl_err = 1'b1;
         else                inflight_next = inflight - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wptr          <= '0;
         rptr          <= '0;
         count         <= '0;
         inflight      <= '0;
         sticky        <= '0;
         err_overrun_o <= 1'b0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
         inflight <= inflight_next;
         // A same-cycle set takes precedence over the clear.
         if (push)              sticky <= (clr_sticky_i ? fp32_flags_t'('0) : sticky) | wdata.flags;
         else if (clr_sticky_i) sticky <= '0;
         if (drop || infl_err)  err_overrun_o <= 1'b1;
         else if (clr_sticky_i) err_overrun_o <= 1'b0;
      end
   end

   fp32_result_fifo_mem #(.DEPTH(DEPTH)) u_mem (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .we     (push),
      .waddr  (wptr),
      .wdata  (wdata),
      .raddr  (rptr),
      .rdata  (rdata)
   );

   assign m_valid_o      = (count != '0);
   assign m_result_o     = rdata.result;
   assign m_flags_o      = rdata.flags;
   assign count_o        = count;
   assign sticky_flags_o = sticky;
   assign issue_ok_o     = ((SW'(count) + SW'(inflight)) < SW'(DEPTH)) && (inflight != MAX_C);

endmodule

// File: tb/tb_fp32_result_fifo.sv
// tb/tb_fp32_result_fifo.sv - directed self-checking bench for fp32_result_fifo.
module tb_fp32_result_fifo;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        issue = 1'b0, done = 1'b0;
   logic [31:0] result = '0;
   logic        overflow = 1'b0, underflow = 1'b0, invalid = 1'b0;
   logic        m_valid;
   logic [31:0] m_result;
   logic [2:0]  m_flags;
   logic        m_ready = 1'b0;
   logic        issue_ok;
   logic [3:0]  count;
   logic [2:0]  sticky;
   logic        clr_sticky = 1'b0;
   logic        err_overrun;

   int compared = 0;
   int mismatched = 0;

   fp32_result_fifo #(.DEPTH(8), .MAX_INFLIGHT(8)) dut (
      .clk_i(clk), .rstn_i(rstn), .issue_i(issue), .done_i(done), .result_i(result),
      .overflow_i(overflow), .underflow_i(underflow), .invalid_i(invalid),
      .m_valid_o(m_valid), .m_result_o(m_result), .m_flags_o(m_flags), .m_ready_i(m_ready),
      .issue_ok_o(issue_ok), .count_o(count), .sticky_flags_o(sticky),
      .clr_sticky_i(clr_sticky), .err_overrun_o(err_overrun)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_done(input logic [31:0] r, input logic [2:0] f);
      done = 1'b1; result = r;
      {invalid, overflow, underflow} = f;
   endtask

   task automatic clear_in();
      issue = 1'b0; done = 1'b0; result = '0;
      {invalid, overflow, underflow} = 3'b000;
      m_ready = 1'b0; clr_sticky = 1'b0;
   endtask

   task automatic do_add(input logic [31:0] r, input logic [2:0] f);
      issue = 1'b1; tick(); issue = 1'b0;
      set_done(r, f); tick(); clear_in();
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (5) tick();
      compared++; if (count !== 4'd0) begin mismatched++; $display("FAIL reset_count_in got %0d exp 0", count); end
      rstn = 1'b1;
      tick();
      compared++; if (count !== 4'd0) begin mismatched++; $display("FAIL reset_count got %0d exp 0", count); end
      compared++; if (m_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %b exp 0", m_valid); end
      compared++; if (issue_ok !== 1'b1) begin mismatched++; $display("FAIL reset_issue_ok got %b exp 1", issue_ok); end
      compared++; if (sticky !== 3'b000) begin mismatched++; $display("FAIL reset_sticky got %b exp 000", sticky); end
      compared++; if (m_result !== 32'h0) begin mismatched++; $display("FAIL reset_result got %h exp 00000000", m_result); end
      compared++; if (err_overrun !== 1'b0) begin mismatched++; $display("FAIL reset_err got %b exp 0", err_overrun); end
   endtask

   task automatic test_basic();
      do_add(32'h3F800000, 3'b000);
      do_add(32'h40000000, 3'b000);
      compared++; if (count !== 4'd2) begin mismatched++; $display("FAIL basic_count got %0d exp 2", count); end
      compared++; if (m_result !== 32'h3F800000) begin mismatched++; $display("FAIL basic_head0 got %h exp 3f800000", m_result); end
      m_ready = 1'b1; tick();
      compared++; if (m_result !== 32'h40000000) begin mismatched++; $display("FAIL basic_head1 got %h exp 40000000", m_result); end
      compared++; if (m_valid !== 1'b1) begin mismatched++; $display("FAIL basic_valid1 got %b exp 1", m_valid); end
      tick();
      compared++; if (m_valid !== 1'b0) begin mismatched++; $display("FAIL basic_empty got %b exp 0", m_valid); end
      tick();
      compared++; if (count !== 4'd0) begin mismatched++; $display("FAIL basic_empty_ready got %0d exp 0", count); end
      clear_in();
      compared++; if (err_overrun !== 1'b0) begin mismatched++; $display("FAIL basic_err got %b exp 0", err_overrun); end
   endtask

   task automatic test_full();
      for (int i = 0; i < 8; i++) begin
         compared++; if (issue_ok !== 1'b1) begin mismatched++; $display("FAIL full_issue_ok_%0d got %b exp 1", i, issue_ok); end
         issue = 1'b1; tick();
      end
      issue = 1'b0;
      compared++; if (issue_ok !== 1'b0) begin mismatched++; $display("FAIL full_issue_ok_8 got %b exp 0", issue_ok); end
      for (int i = 0; i < 8; i++) begin
         set_done(32'h100 + i, 3'b000); tick();
      end
      clear_in();
      compared++; if (count !== 4'd8) begin mismatched++; $display("FAIL full_count got %0d exp 8", count); end
      compared++; if (issue_ok !== 1'b0) begin mismatched++; $display("FAIL full_issue_ok got %b exp 0", issue_ok); end
      compared++; if (err_overrun !== 1'b0) begin mismatched++; $display("FAIL full_err_pre got %b exp 0", err_overrun); end
      issue = 1'b1; tick(); issue = 1'b0;
      set_done(32'h0000DEAD, 3'b000); tick(); clear_in();
      compared++; if (err_overrun !== 1'b1) begin mismatched++; $display("FAIL full_drop_err got %b exp 1", err_overrun); end
      compared++; if (count !== 4'd8) begin mismatched++; $display("FAIL full_drop_count got %0d exp 8", count); end
      compared++; if (m_result !== 32'h100) begin mismatched++; $display("FAIL full_drop_head got %h exp 00000100", m_result); end
      clr_sticky = 1'b1; tick(); clear_in();
      compared++; if (err_overrun !== 1'b0) begin mismatched++; $display("FAIL full_clr_err got %b exp 0", err_overrun); end
      issue = 1'b1; tick(); issue = 1'b0;
      set_done(32'h0000BEEF, 3'b000); m_ready = 1'b1; tick(); clear_in();
      compared++; if (count !== 4'd8) begin mismatched++; $display("FAIL full_pushpop_count got %0d exp 8", count); end
      compared++; if (err_overrun !== 1'b0) begin mismatched++; $display("FAIL full_pushpop_err got %b exp 0", err_overrun); end
      for (int i = 1; i < 9; i++) begin
         logic [31:0] exp_r;
         exp_r = (i == 8) ? 32'h0000BEEF : 32'h100 + i;
         compared++; if (m_result !== exp_r) begin mismatched++; $display("FAIL full_drain_%0d got %h exp %h", i, m_result, exp_r); end
         m_ready = 1'b1; tick();
      end
      clear_in();
      compared++; if (m_valid !== 1'b0) begin mismatched++; $display("FAIL full_drained got %b exp 0", m_valid); end
   endtask

   task automatic test_sticky();
      do_add(32'h7F800000, 3'b010);
      do_add(32'hFFC00001, 3'b100);
      compared++; if (sticky !== 3'b110) begin mismatched++; $display("FAIL sticky_or got %b exp 110", sticky); end
      compared++; if (m_flags !== 3'b010) begin mismatched++; $display("FAIL sticky_head_flags got %b exp 010", m_flags); end
      compared++; if (m_result !== 32'h7F800000) begin mismatched++; $display("FAIL sticky_inf_kept got %h exp 7f800000", m_result); end
      m_ready = 1'b1; tick(); tick(); clear_in();
      clr_sticky = 1'b1; tick(); clear_in();
      compared++; if (sticky !== 3'b000) begin mismatched++; $display("FAIL sticky_clr got %b exp 000", sticky); end
      issue = 1'b1; tick(); issue = 1'b0;
      set_done(32'h7F800000, 3'b010); clr_sticky = 1'b1; tick(); clear_in();
      compared++; if (sticky !== 3'b010) begin mismatched++; $display("FAIL sticky_set_wins got %b exp 010", sticky); end
      m_ready = 1'b1; tick(); clear_in();
   endtask

   task automatic test_nan();
      logic [31:0] exp_r;
`ifdef FP32_RESULT_FIFO_NAN_CANON_EN
      exp_r = 32'h7FC00000;
`else
      exp_r = 32'h7F812345;
`endif
      do_add(32'h7F812345, 3'b100);
      compared++; if (m_result !== exp_r) begin mismatched++; $display("FAIL nan_result got %h exp %h", m_result, exp_r); end
      compared++; if (m_flags !== 3'b100) begin mismatched++; $display("FAIL nan_flags got %b exp 100", m_flags); end
      m_ready = 1'b1; tick(); clear_in();
   endtask

   task automatic test_back_to_back();
      issue = 1'b1; tick();
      for (int i = 1; i <= 20; i++) begin
         issue = (i < 20);
         set_done(32'(i), 3'b000);
         m_ready = 1'b1;
         tick();
         compared++; if (m_result !== 32'(i)) begin mismatched++; $display("FAIL b2b_head_%0d got %h exp %h", i, m_result, 32'(i)); end
         compared++; if (count > 4'd2) begin mismatched++; $display("FAIL b2b_count_%0d got %0d exp <=2", i, count); end
      end
      clear_in();
      m_ready = 1'b1; tick(); clear_in();
      compared++; if (count !== 4'd0) begin mismatched++; $display("FAIL b2b_final_count got %0d exp 0", count); end
      compared++; if (err_overrun !== 1'b0) begin mismatched++; $display("FAIL b2b_err got %b exp 0", err_overrun); end
      compared++; if (issue_ok !== 1'b1) begin mismatched++; $display("FAIL b2b_issue_ok got %b exp 1", issue_ok); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_sticky();
      test_nan();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/fp32_result_fifo.md
Name: fp32_result_fifo

Overview:
- Downstream stage of the pipelined fp32 adder.
- Captures every adder completion, meaning result_o together with the overflow/underflow/invalid flags, into a show-ahead FIFO.
- Presents the buffered results to the consumer over a valid/ready interface.
- The adder has no backpressure, so this block also tracks in-flight adds and drives issue_ok_o. The issuer may pulse the adder's valid_i only when issue_ok_o=1, which guarantees every result has a slot.

Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥2.
- MAX_INFLIGHT, 8, maximum outstanding adds; sets the in-flight counter width; must be ≥ adder latency.

Ports:
- clk_i  in  1  clock, rising edge
- rstn_i  in  1  asynchronous active-low reset
- issue_i  in  1  copy of adder valid_i; an add was launched this cycle
- done_i  in  1  adder done_o
- result_i  in  32  adder result_o
- overflow_i  in  1  adder overflow_o
- underflow_i  in  1  adder underflow_o
- invalid_i  in  1  adder invalid_o
- m_valid_o  out  1  head entry available
- m_result_o  out  32  head result
- m_flags_o  out  3  head flags {invalid,overflow,underflow}
- m_ready_i  in  1  consumer accepts head
- issue_ok_o  out  1  safe to issue another add this cycle
- count_o  out  $clog2(DEPTH)+1  stored entries
- sticky_flags_o  out  3  OR of all flags pushed since last clear
- clr_sticky_i  in  1  clears sticky_flags_o and err_overrun_o
- err_overrun_o  out  1  sticky; a completion was dropped

Behaviour:
- Reset (async assert, sync release): pointers, count, in-flight counter, sticky flags and err_overrun_o all 0. m_valid_o=0, issue_ok_o=1, count_o=0, m_result_o/m_flags_o=0.
- Push:
  - Occurs when done_i=1 and (count<DEPTH or pop this cycle).
  - Stores {result_i, invalid_i, overflow_i, underflow_i} at the write pointer.
  - Write pointer wraps modulo DEPTH.
- Pop: occurs when m_valid_o & m_ready_i; read pointer advances with wrap.
- Show-ahead output:
  - m_valid_o = (count≠0).
  - m_result_o/m_flags_o read the head entry combinationally from storage.
  - A pushed entry is visible the cycle after done_i; write-to-read latency is 1.
- count update: +1 on push only, −1 on pop only, unchanged on both.
- Full with done_i=1 and pop in the same cycle: accepted, count stays DEPTH.
- Full with done_i=1 and no pop: entry dropped, storage unchanged, err_overrun_o set next cycle.
- Empty: m_ready_i is ignored; the read pointer does not move.
- In-flight counter: +1 on issue_i only, −1 on done_i only, unchanged on both.
  - done_i with inflight=0 is a protocol error: saturate at 0 and set err_overrun_o.
  - issue_i with inflight=MAX_INFLIGHT: saturate and set err_overrun_o.
- issue_ok_o (combinational from registers): (count + inflight) < DEPTH and inflight < MAX_INFLIGHT. It does not credit a same-cycle pop.
- Sticky flags:
  - sticky_flags_o |= pushed flags on each accepted push.
  - clr_sticky_i zeroes sticky_flags_o and err_overrun_o.
  - If a clear and a set occur in the same cycle, the new set wins.
- Reset mid-operation: all state, including in-flight, is discarded. The adder must be reset in the same domain.

Optional Feature:
- FP32_RESULT_FIFO_NAN_CANON_EN defined: any pushed result with exponent=8'hFF and mantissa≠0 is stored as 32'h7FC00000, and the flag bits are unchanged.
- Not defined: results are stored bit-exact.

Decomposition:
- Package fp32_result_pkg:
  - typedef fp32_flags_t, a packed struct {invalid, overflow, underflow}.
  - typedef fp32_entry_t, a packed struct {result[31:0], flags}.
  - localparam CANON_QNAN=32'h7FC00000.
  - localparam FP32_EXP_MAX=8'hFF.
- Sub-module fp32_result_fifo_mem: DEPTH×fp32_entry_t register array with write enable, write/read pointers and combinational read.

Test Plan:
1. Reset: hold rstn_i=0 for 5 cycles → count_o=0, m_valid_o=0, issue_ok_o=1, sticky_flags_o=0.
2. Push 3F800000, then 40000000 (flags 0) with m_ready_i=0 → count_o=2. Raise m_ready_i → m_result_o=3F800000, then 40000000, then m_valid_o=0.
3. DEPTH=8, m_ready_i=0: issue 8 adds and complete them → issue_ok_o=0 after the 8th issue, count_o=8. A 9th done_i without a pop → dropped, err_overrun_o=1. With m_ready_i=1 in the same cycle as done_i → accepted, count_o stays 8.
4. Push 7F800000 with overflow_i=1, then FFC00001 with invalid_i=1 → sticky_flags_o=3'b110. clr_sticky_i → 0. A simultaneous clr and overflow push → 3'b010.
5. With FP32_RESULT_FIFO_NAN_CANON_EN: push 7F812345 → m_result_o=7FC00000. Without the macro → 7F812345.
6. Wrap-around: 20 back-to-back issue/done/pop cycles with ascending results 00000001..00000014 → output order preserved, count_o never exceeds 2, no err_overrun_o.
